// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide memory port between instruction fetch and load/store,
// sequencing multi-byte accesses and extending loads.
module mem_arbiter #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);
    typedef enum logic [1:0] {IDLE, RD, RD_LAST, WR} state_t;
    state_t      state;
    logic [2:0]  cnt, n;
    logic [1:0]  size, idx;
    logic [31:0] base, wdata, rbuf, word, ext;
    logic        uns, owner, last_grant;
    logic        if_ok, ls_ok, pick_ls, stall;
    always_comb begin
        if_ok    = if_req && !if_done && !flush;
        ls_ok    = ls_req && !ls_done && !flush;
        pick_ls  = ls_ok && (!if_ok || !last_grant);
        mem_a    = (state == RD || state == WR) ? base + {29'b0, cnt} : 32'b0;
        stall    = mem_a[17:16] == IO_HI && io_buffer_full;
        mem_wr   = rdy && state == WR && !stall;
        mem_dout = state == WR ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'b0;
        // mem_din always belongs to the address presented one cycle earlier
        idx      = cnt[1:0] - 2'd1;
        word     = rbuf;
        word[{idx, 3'b000} +: 8] = mem_din;
        ext      = size == 2'd0 ? {{24{!uns && word[7]}}, word[7:0]} :
                   size == 2'd1 ? {{16{!uns && word[15]}}, word[15:0]} : word;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            n          <= 3'd0;
            size       <= 2'd0;
            base       <= 32'b0;
            wdata      <= 32'b0;
            rbuf       <= 32'b0;
            uns        <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            if_done    <= 1'b0;
            ls_done    <= 1'b0;
            if_data    <= 32'b0;
            ls_rdata   <= 32'b0;
        end else if (rdy) begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                IDLE: if (if_ok || ls_ok) begin
                    owner      <= pick_ls;
                    last_grant <= pick_ls;
                    cnt        <= 3'd0;
                    rbuf       <= 32'b0;
                    base       <= pick_ls ? ls_addr : if_addr;
                    size       <= pick_ls ? ls_size : 2'd2;
                    n          <= (!pick_ls || ls_size[1]) ? 3'd4 : ls_size[0] ? 3'd2 : 3'd1;
                    uns        <= ls_unsigned;
                    wdata      <= ls_wdata;
                    state      <= (pick_ls && ls_wr) ? WR : RD;
                end
                RD: begin
                    if (cnt != 3'd0) rbuf <= word;
                    cnt   <= cnt + 3'd1;
                    state <= flush ? IDLE : (cnt == n - 3'd1) ? RD_LAST : RD;
                end
                RD_LAST: begin
                    state <= IDLE;
                    if (!flush && owner) begin
                        ls_done  <= 1'b1;
                        ls_rdata <= ext;
                    end
                    if (!flush && !owner) begin
                        if_done <= 1'b1;
                        if_data <= word;
                    end
                end
                WR: if (!stall) begin
                    cnt <= cnt + 3'd1;
                    if (cnt == n - 3'd1) begin
                        state   <= IDLE;
                        ls_done <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a byte RAM model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst, rdy, flush, io_buffer_full;
    logic        if_req, if_done, ls_req, ls_wr, ls_unsigned, ls_done, mem_wr;
    logic [1:0]  ls_size;
    logic [31:0] if_addr, if_data, ls_addr, ls_wdata, ls_rdata, mem_a;
    logic [7:0]  mem_din, mem_dout;
    logic [7:0]  ram  [int unsigned];
    logic [7:0]  wmem [int unsigned];
    logic [31:0] if_q[$];
    logic [32:0] ls_q[$];
    logic [39:0] wr_q[$];
    int          n_chk = 0, n_fail = 0, wr_cnt = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    // RAM read pipeline pauses with the rest of the system while rdy is low
    always @(posedge clk) begin
        if (rdy) mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        if (mem_wr) wmem[mem_a] = mem_dout;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] ei;
        logic [32:0] el;
        logic [39:0] ew;
        if (if_done) begin
            chk("if_expected", if_q.size() != 0, 1);
            if (if_q.size() != 0) begin
                ei = if_q.pop_front();
                chk("if_data", if_data, ei);
            end
        end
        if (ls_done) begin
            chk("ls_expected", ls_q.size() != 0, 1);
            if (ls_q.size() != 0) begin
                el = ls_q.pop_front();
                if (el[32]) chk("ls_rdata", ls_rdata, el[31:0]);
            end
        end
        if (mem_wr) begin
            wr_cnt++;
            chk("wr_expected", wr_q.size() != 0, 1);
            if (wr_q.size() != 0) begin
                ew = wr_q.pop_front();
                chk("wr_addr_byte", {mem_a, mem_dout}, ew);
            end
        end
    end

    task automatic run(input string tag, input bit f, wr, input logic [1:0] sz, input bit un,
                       input logic [31:0] a, wd, ex, input int fl, rl, elat);
        int lat;
        if (f) begin
            if_q.push_back(ex);
            if_req = 1; if_addr = a;
        end else begin
            ls_q.push_back({!wr, ex});
            ls_req = 1; ls_wr = wr; ls_size = sz; ls_unsigned = un; ls_addr = a; ls_wdata = wd;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            flush = lat == fl;
            rdy = !(rl != 0 && (lat == rl || lat == rl + 1));
        end while (!(f ? if_done : ls_done) && lat < 30);
        if (!(f ? if_done : ls_done)) lat = -1;
        chk({tag, "_latency"}, lat, elat);
        if_req = 0; ls_req = 0; flush = 0; rdy = 1;
        @(negedge clk);
        chk({tag, "_pulse"}, f ? if_done : ls_done, 0);
    endtask

    task automatic collide(output int it, output int lt);
        if_q.push_back(32'h13);
        ls_q.push_back({1'b1, 32'h0000_9234});
        if_req = 1; if_addr = 32'h100;
        ls_req = 1; ls_wr = 0; ls_size = 2; ls_unsigned = 0; ls_addr = 32'h210;
        it = -1; lt = -1;
        for (int c = 1; c <= 30 && (if_req || ls_req); c++) begin
            @(negedge clk);
            if (if_done && if_req) begin it = c; if_req = 0; end
            if (ls_done && ls_req) begin lt = c; ls_req = 0; end
        end
        if_req = 0; ls_req = 0;
        @(negedge clk);
    endtask

    initial begin
        int w0, it, lt;
        logic seen;
        rst = 0; rdy = 1; flush = 0; io_buffer_full = 0;
        if_req = 0; if_addr = 0; ls_req = 0; ls_wr = 0; ls_size = 0; ls_unsigned = 0;
        ls_addr = 0; ls_wdata = 0;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h00; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        ram[32'h200] = 8'h80; ram[32'h210] = 8'h34; ram[32'h211] = 8'h92;
        @(negedge clk);
        chk("reset_port", {mem_a, mem_dout, mem_wr, if_done, ls_done}, 0);
        chk("reset_data", {if_data, ls_rdata}, 0);
        rst = 1;
        @(negedge clk);
        // word fetch with the address walk checked byte by byte
        if_q.push_back(32'h0000_0013);
        if_req = 1; if_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fetch_addr", {mem_wr, mem_a}, {1'b0, 32'h100 + k});
        end
        @(negedge clk);
        chk("fetch_early", if_done, 0);
        @(negedge clk);
        chk("fetch_done", if_done, 1);
        if_req = 0;
        @(negedge clk);
        // loads with extension
        run("lb",  0, 0, 2'd0, 0, 32'h200, 0, 32'hFFFF_FF80, 0, 0, 3);
        run("lbu", 0, 0, 2'd0, 1, 32'h200, 0, 32'h0000_0080, 0, 0, 3);
        run("lh",  0, 0, 2'd1, 0, 32'h210, 0, 32'hFFFF_9234, 0, 0, 4);
        run("lhu", 0, 0, 2'd1, 1, 32'h210, 0, 32'h0000_9234, 0, 0, 4);
        run("lw3", 0, 0, 2'd3, 0, 32'h100, 0, 32'h0000_0013, 0, 0, 6);
        // word store
        wr_q.push_back({32'h40, 8'hEF}); wr_q.push_back({32'h41, 8'hBE});
        wr_q.push_back({32'h42, 8'hAD}); wr_q.push_back({32'h43, 8'hDE});
        w0 = wr_cnt;
        run("sw", 0, 1, 2'd2, 0, 32'h40, 32'hDEAD_BEEF, 0, 0, 0, 5);
        chk("sw_count", wr_cnt - w0, 4);
        // round-robin from reset, then with LS as the last grant
        rst = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        collide(it, lt);
        chk("rr1_ls_first", lt, 6);
        chk("rr1_if_second", it, 12);
        run("lb_pos", 0, 0, 2'd0, 0, 32'h210, 0, 32'h0000_0034, 0, 0, 3);
        collide(it, lt);
        chk("rr2_if_first", it, 6);
        chk("rr2_ls_second", lt, 12);
        // flush aborts a fetch
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        @(negedge clk);
        flush = 1; if_req = 0;
        @(negedge clk);
        flush = 0;
        chk("flush_idle", mem_a, 0);
        seen = if_done;
        repeat (8) begin
            @(negedge clk);
            seen = seen | if_done;
        end
        chk("flush_no_done", seen, 0);
        // flush does not stop a store
        wr_q.push_back({32'h50, 8'h44}); wr_q.push_back({32'h51, 8'h33});
        wr_q.push_back({32'h52, 8'h22}); wr_q.push_back({32'h53, 8'h11});
        w0 = wr_cnt;
        run("sw_flush", 0, 1, 2'd2, 0, 32'h50, 32'h1122_3344, 0, 2, 0, 5);
        chk("sw_flush_count", wr_cnt - w0, 4);
        // IO stall on a byte store
        wr_q.push_back({32'h30000, 8'h5A});
        ls_q.push_back({1'b0, 32'h0});
        w0 = wr_cnt;
        ls_req = 1; ls_wr = 1; ls_size = 0; ls_addr = 32'h30000; ls_wdata = 32'h5A;
        io_buffer_full = 1;
        repeat (3) begin
            @(negedge clk);
            chk("io_stall", {mem_wr, mem_a}, {1'b0, 32'h30000});
        end
        @(posedge clk);
        #1 io_buffer_full = 0;
        @(negedge clk);
        chk("io_write", {mem_wr, mem_dout}, {1'b1, 8'h5A});
        @(negedge clk);
        chk("io_done", ls_done, 1);
        ls_req = 0;
        chk("io_count", wr_cnt - w0, 1);
        @(negedge clk);
        // rdy freeze mid-load
        run("lw_rdy", 0, 0, 2'd2, 0, 32'h100, 0, 32'h0000_0013, 0, 2, 8);
        // reset in the middle of a store
        wr_q.push_back({32'h60, 8'h04});
        ls_req = 1; ls_wr = 1; ls_size = 2; ls_addr = 32'h60; ls_wdata = 32'h0102_0304;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 0; ls_req = 0;
        #1 chk("rst_mid_wr", {mem_wr, mem_a}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("rst_idle", {mem_wr, mem_a, ls_done}, 0);
        chk("rst_no_byte1", wmem.exists(32'h61), 0);
        chk("queues_empty", {if_q.size() != 0, ls_q.size() != 0, wr_q.size() != 0}, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
